psimd_issue_ctrl: RTL and testbench

//  Sequences one PSIMD DLFloat instruction at a time through the 4-lane datapath.
//  - Captures operands and drives them into the lane splitter.
//  - Starts the lane array and waits for completion or timeout.
//  - Packs the result into one or two 64-bit register-file writebacks.
//  - Sits between the decode/issue stage and the register-file write port.

---
 rtl/psimd_pkg.sv | 31 +++
 rtl/psimd_issue_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_psimd_issue_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/psimd_pkg.sv
// Shared types and constants for the PSIMD DLFloat issue path.
//   psimd_op_e    : opcode encoding seen on in_op_i / lane_op_o
//   psimd_state_e : issue controller states
//   is_legal_op() : true for the five implemented opcodes
package psimd_pkg;

  localparam int unsigned LANES = 4;
  localparam int unsigned FP_W  = 16;
  localparam int unsigned INT_W = 32;

  typedef enum logic [3:0] {
    OpFadd = 4'h0,
    OpFmul = 4'h1,
    OpFma  = 4'h2,
    OpF2i  = 4'h3,
    OpI2f  = 4'h4
  } psimd_op_e;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StIssue = 3'd1,
    StWait  = 3'd2,
    StWb0   = 3'd3,
    StWb1   = 3'd4
  } psimd_state_e;

  function automatic logic is_legal_op(input logic [3:0] op);
    return op <= 4'(OpI2f);
  endfunction

endpackage

// File: rtl/psimd_issue_ctrl.sv
// PSIMD issue controller: runs one DLFloat instruction at a time through the
// 4-lane datapath and returns the result as one or two register-file beats.
//
// Ports
//   clk_i, rst_i              : clock, synchronous active-high reset
//   in_valid_i / in_ready_o   : issue handshake (ready only when idle)
//   in_op_i, in_rd_i          : opcode and destination register
//   in_src1_i..in_src3_i      : source operands (src3 only used by FMA)
//   op_src1_o..op_src3_o      : captured operands to the lane splitter
//   lane_op_o, lane_start_o   : captured opcode, one-cycle start pulse
//   lane_done_i               : lane array completion pulse
//   res_f_i, res_i0_i, res_i1_i : packed FP result, packed int lanes 0-1 / 2-3
//   wb_valid_o / wb_ready_i   : writeback beat handshake
//   wb_rd_o, wb_data_o, wb_err_o : beat register, data, error flag
//   busy_o                    : high whenever not idle
module psimd_issue_ctrl
  import psimd_pkg::*;
#(
  parameter int unsigned REG_WIDTH   = 64,
  parameter int unsigned RD_W        = 5,
  parameter int unsigned TIMEOUT_CYC = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [3:0]           in_op_i,
  input  logic [RD_W-1:0]      in_rd_i,
  input  logic [REG_WIDTH-1:0] in_src1_i,
  input  logic [REG_WIDTH-1:0] in_src2_i,
  input  logic [REG_WIDTH-1:0] in_src3_i,
  output logic [REG_WIDTH-1:0] op_src1_o,
  output logic [REG_WIDTH-1:0] op_src2_o,
  output logic [REG_WIDTH-1:0] op_src3_o,
  output logic [3:0]           lane_op_o,
  output logic                 lane_start_o,
  input  logic                 lane_done_i,
  input  logic [REG_WIDTH-1:0] res_f_i,
  input  logic [REG_WIDTH-1:0] res_i0_i,
  input  logic [REG_WIDTH-1:0] res_i1_i,
  output logic                 wb_valid_o,
  input  logic                 wb_ready_i,
  output logic [RD_W-1:0]      wb_rd_o,
  output logic [REG_WIDTH-1:0] wb_data_o,
  output logic                 wb_err_o,
  output logic                 busy_o
);

  localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

  psimd_state_e         state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [3:0]           op_q, op_d;
  logic [RD_W-1:0]      rd_q, rd_d;
  logic [REG_WIDTH-1:0] src1_q, src1_d;
  logic [REG_WIDTH-1:0] src2_q, src2_d;
  logic [REG_WIDTH-1:0] src3_q, src3_d;
  logic [REG_WIDTH-1:0] res_f_q, res_f_d;
  logic [REG_WIDTH-1:0] res_i0_q, res_i0_d;
  logic [REG_WIDTH-1:0] res_i1_q, res_i1_d;
  logic                 err_q, err_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      src3_q   <= '0;
      res_f_q  <= '0;
      res_i0_q <= '0;
      res_i1_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      src3_q   <= src3_d;
      res_f_q  <= res_f_d;
      res_i0_q <= res_i0_d;
      res_i1_q <= res_i1_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic. Operands and opcode only change on an accepted request,
  // so they stay stable for the whole instruction.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    rd_d     = rd_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    src3_d   = src3_q;
    res_f_d  = res_f_q;
    res_i0_d = res_i0_q;
    res_i1_d = res_i1_q;
    err_d    = err_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          op_d   = in_op_i;
          rd_d   = in_rd_i;
          src1_d = in_src1_i;
          src2_d = in_src2_i;
          src3_d = in_src3_i;
          if (is_legal_op(in_op_i)) begin
            err_d   = 1'b0;
            state_d = StIssue;
          end else begin
            // Illegal opcode never reaches the lanes.
            err_d   = 1'b1;
            state_d = StWb0;
          end
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q + CntW'(1);
        // A completion on the final allowed cycle still counts as success.
        if (lane_done_i) begin
          res_f_d  = res_f_i;
          res_i0_d = res_i0_i;
          res_i1_d = res_i1_i;
          state_d  = StWb0;
        end else if (cnt_q == CntLast) begin
          err_d   = 1'b1;
          state_d = StWb0;
        end
      end
      StWb0: begin
        if (wb_ready_i) begin
          if ((op_q == 4'(OpF2i)) && !err_q) begin
            state_d = StWb1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StWb1: begin
        if (wb_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    in_ready_o   = (state_q == StIdle);
    busy_o       = (state_q != StIdle);
    lane_start_o = (state_q == StIssue);
    wb_valid_o   = 1'b0;
    wb_rd_o      = '0;
    wb_data_o    = '0;
    wb_err_o     = 1'b0;

    unique case (state_q)
      StWb0: begin
        wb_valid_o = 1'b1;
        wb_rd_o    = rd_q;
        wb_err_o   = err_q;
        if (!err_q) begin
          wb_data_o = (op_q == 4'(OpF2i)) ? res_i0_q : res_f_q;
        end
      end
      StWb1: begin
        wb_valid_o = 1'b1;
        // Second half of an F2I result goes to the next register, wrapping.
        wb_rd_o    = rd_q + RD_W'(1);
        wb_data_o  = res_i1_q;
      end
      default: ;
    endcase
  end

  assign op_src1_o = src1_q;
  assign op_src2_o = src2_q;
  assign op_src3_o = src3_q;
  assign lane_op_o = op_q;

endmodule

// File: tb/tb_psimd_issue_ctrl.sv
// Randomised bench for psimd_issue_ctrl with a transaction-level reference
// model: each instruction is reduced to a list of expected writeback beats.
module tb_psimd_issue_ctrl;

  localparam int TO = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_rd;
  logic [63:0] in_src1, in_src2, in_src3;
  logic [63:0] op_src1, op_src2, op_src3;
  logic [3:0]  lane_op;
  logic        lane_start, lane_done;
  logic [63:0] res_f, res_i0, res_i1;
  logic        wb_valid, wb_ready, wb_err, busy;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  psimd_issue_ctrl #(
    .REG_WIDTH  (64),
    .RD_W       (5),
    .TIMEOUT_CYC(TO)
  ) u_dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_op_i     (in_op),
    .in_rd_i     (in_rd),
    .in_src1_i   (in_src1),
    .in_src2_i   (in_src2),
    .in_src3_i   (in_src3),
    .op_src1_o   (op_src1),
    .op_src2_o   (op_src2),
    .op_src3_o   (op_src3),
    .lane_op_o   (lane_op),
    .lane_start_o(lane_start),
    .lane_done_i (lane_done),
    .res_f_i     (res_f),
    .res_i0_i    (res_i0),
    .res_i1_i    (res_i1),
    .wb_valid_o  (wb_valid),
    .wb_ready_i  (wb_ready),
    .wb_rd_o     (wb_rd),
    .wb_data_o   (wb_data),
    .wb_err_o    (wb_err),
    .busy_o      (busy)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
    logic        err;
  } beat_t;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic jitter_results();
    res_f  = rnd64();
    res_i0 = rnd64();
    res_i1 = rnd64();
  endtask

  // Entry/exit: just after a rising edge with the DUT idle.
  // dly = WAIT cycle (1-based, counted from the lane_start cycle) carrying
  // lane_done; 0 or anything past TO means the lanes never answer.
  // bp  = backpressure cycles per beat, or -1 for random 0..3.
  task automatic run_txn(input logic [3:0] op, input logic [4:0] rd, input int dly,
                         input int bp, input logic [63:0] rf, input logic [63:0] ri0,
                         input logic [63:0] ri1);
    logic [63:0] s1, s2, s3;
    beat_t       exp_q[$];
    beat_t       b;
    bit          legal, timed_out;
    int          dec, nbp;

    s1 = rnd64();
    s2 = rnd64();
    s3 = rnd64();
    legal     = (op <= 4'h4);
    timed_out = (dly < 1) || (dly > TO);
    dec       = timed_out ? TO : dly;

    in_valid = 1'b1;
    in_op    = op;
    in_rd    = rd;
    in_src1  = s1;
    in_src2  = s2;
    in_src3  = s3;
    @(negedge clk);
    check_eq("in_ready_idle", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_op    = 4'($urandom);
    in_rd    = 5'($urandom);
    in_src1  = rnd64();

    if (legal) begin
      @(negedge clk);
      check_eq("lane_start", lane_start, 1'b1);
      check_eq("busy", busy, 1'b1);
      check_eq("in_ready_busy", in_ready, 1'b0);
      check_eq("lane_op", lane_op, op);
      check_eq("op_src1", op_src1, s1);
      check_eq("op_src2", op_src2, s2);
      check_eq("op_src3", op_src3, s3);
      for (int k = 1; k <= dec; k++) begin
        @(posedge clk); #1;
        jitter_results();
        lane_done = (k == dly);
        if (k == dly) begin
          res_f  = rf;
          res_i0 = ri0;
          res_i1 = ri1;
        end
        @(negedge clk);
        check_eq("wait_no_wb", wb_valid, 1'b0);
        check_eq("wait_no_start", lane_start, 1'b0);
      end
      check_eq("op_src1_held", op_src1, s1);
      check_eq("op_src3_held", op_src3, s3);
      @(posedge clk); #1;
      lane_done = 1'b0;
    end

    // Reference model: which beats the register file must see.
    b.rd  = rd;
    b.err = !legal || timed_out;
    b.data = b.err ? 64'h0 : ((op == 4'h3) ? ri0 : rf);
    exp_q.push_back(b);
    if (op == 4'h3 && !b.err) begin
      b.rd   = rd + 5'd1;
      b.data = ri1;
      b.err  = 1'b0;
      exp_q.push_back(b);
    end

    foreach (exp_q[i]) begin
      nbp = (bp < 0) ? int'($urandom_range(0, 3)) : bp;
      for (int c = 0; c <= nbp; c++) begin
        wb_ready  = (c == nbp);
        in_valid  = (c != nbp) ? 1'($urandom) : 1'b0;
        lane_done = 1'($urandom);  // ignored outside WAIT
        jitter_results();
        @(negedge clk);
        check_eq("wb_valid", wb_valid, 1'b1);
        check_eq("wb_rd", wb_rd, exp_q[i].rd);
        check_eq("wb_data", wb_data, exp_q[i].data);
        check_eq("wb_err", wb_err, exp_q[i].err);
        check_eq("wb_in_ready", in_ready, 1'b0);
        check_eq("wb_no_start", lane_start, 1'b0);
        @(posedge clk); #1;
      end
    end
    wb_ready  = 1'b0;
    in_valid  = 1'b0;
    lane_done = 1'b0;
    @(negedge clk);
    check_eq("back_idle_ready", in_ready, 1'b1);
    check_eq("back_idle_wb", wb_valid, 1'b0);
    check_eq("back_idle_busy", busy, 1'b0);
    @(posedge clk); #1;
  endtask

  // Reset in the middle of WAIT, then a stray lane_done must not produce a beat.
  task automatic reset_mid_wait();
    in_valid = 1'b1;
    in_op    = 4'h1;
    in_rd    = 5'd12;
    in_src1  = rnd64();
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_ready", in_ready, 1'b1);
    check_eq("rst_mid_busy", busy, 1'b0);
    check_eq("rst_mid_wb", wb_valid, 1'b0);
    check_eq("rst_mid_src1", op_src1, 64'h0);
    @(posedge clk); #1;
    lane_done = 1'b1;
    @(posedge clk); #1;
    lane_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("late_done_no_wb", wb_valid, 1'b0);
      check_eq("late_done_ready", in_ready, 1'b1);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [3:0] op;
    int         dly;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = '0;
    in_rd     = '0;
    in_src1   = '0;
    in_src2   = '0;
    in_src3   = '0;
    lane_done = 1'b0;
    wb_ready  = 1'b0;
    res_f     = '0;
    res_i0    = '0;
    res_i1    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_in_ready", in_ready, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_wb_valid", wb_valid, 1'b0);
    check_eq("rst_lane_start", lane_start, 1'b0);
    check_eq("rst_lane_op", lane_op, 4'h0);
    check_eq("rst_op_src1", op_src1, 64'h0);
    check_eq("rst_wb_data", wb_data, 64'h0);
    check_eq("rst_wb_rd", wb_rd, 5'h0);
    check_eq("rst_wb_err", wb_err, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed cases.
    run_txn(4'h0, 5'd7, 5, 0, 64'h3C00_3C00_3C00_3C00, rnd64(), rnd64());
    run_txn(4'h3, 5'd31, 3, 0, rnd64(), 64'h1, 64'h2);
    run_txn(4'h1, 5'd3, 2, 4, rnd64(), rnd64(), rnd64());
    run_txn(4'h2, 5'd9, 0, 0, rnd64(), rnd64(), rnd64());       // lanes never answer
    run_txn(4'h2, 5'd9, TO, 0, rnd64(), rnd64(), rnd64());      // done on timeout cycle
    run_txn(4'h2, 5'd9, TO - 1, 1, rnd64(), rnd64(), rnd64());
    run_txn(4'hF, 5'd4, 3, 2, rnd64(), rnd64(), rnd64());       // illegal, no lanes
    run_txn(4'h3, 5'd5, 0, 1, rnd64(), rnd64(), rnd64());       // F2I timeout: one beat
    run_txn(4'h4, 5'd20, 1, 0, rnd64(), rnd64(), rnd64());
    reset_mid_wait();

    // Random traffic.
    for (int t = 0; t < 60; t++) begin
      op = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(5, 15)) : 4'($urandom_range(0, 4));
      case ($urandom_range(0, 9))
        0:       dly = 0;
        1:       dly = TO;
        default: dly = int'($urandom_range(1, 8));
      endcase
      run_txn(op, 5'($urandom), dly, -1, rnd64(), rnd64(), rnd64());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
